// File: rtl/weight_stream_ctrl.sv
// Streams a ROM of MEM_DEPTH words num_passes times to a valid/ready consumer.
// Reads are credit-limited so every in-flight word is guaranteed a FIFO slot.
//
// state  | meaning
// IDLE   | waiting for start; ROM disabled
// STREAM | issuing ROM reads while credit allows
// DRAIN  | all reads issued; emptying pipeline and FIFO
module weight_stream_ctrl #(
  parameter int DATA_WIDTH  = 128,
  parameter int MEM_DEPTH   = 576,
  parameter int ADDR_WIDTH  = $clog2(MEM_DEPTH) + 1,
  parameter int ROM_LATENCY = 2,
  parameter int PASS_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] num_passes,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  localparam int FIFO_DEPTH = ROM_LATENCY + 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [PASS_WIDTH-1:0]  pass_q, npass_q;
  logic [ROM_LATENCY-1:0] vld_sr_q;
  logic [CNT_W-1:0]       infl_q, fifo_cnt_q;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic                   fin_q, zero_q;

  logic accept, zero_start, issue, last_rd, capture, pop, final_hs;
  logic [CNT_W:0] credit_used;

  assign accept      = (state_q == IDLE) && !fin_q && start && (num_passes != '0);
  assign zero_start  = (state_q == IDLE) && !fin_q && start && (num_passes == '0);
  assign credit_used = (CNT_W+1)'(fifo_cnt_q) + (CNT_W+1)'(infl_q);
  assign issue       = (state_q == STREAM) && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign last_rd     = issue && (addr_q == ADDR_WIDTH'(MEM_DEPTH - 1))
                       && (pass_q == npass_q - 1'b1);
  assign capture     = vld_sr_q[ROM_LATENCY-1];
  assign pop         = (fifo_cnt_q != '0) && data_out_ready;
  // Last beat leaves: nothing left in flight and this pop empties the FIFO.
  assign final_hs    = (state_q == DRAIN) && pop && (fifo_cnt_q == CNT_W'(1))
                       && (infl_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = STREAM;
      STREAM:  if (last_rd)  state_d = DRAIN;
      DRAIN:   if (final_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_q != IDLE) || fin_q;
    rom_ce         = (state_q != IDLE);
    done           = fin_q || zero_q;
    rom_addr       = addr_q;
    data_out_valid = (fifo_cnt_q != '0);
    data_out       = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      pass_q     <= '0;
      npass_q    <= '0;
      vld_sr_q   <= '0;
      infl_q     <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fin_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      fin_q    <= final_hs;
      zero_q   <= zero_start;
      vld_sr_q <= (vld_sr_q << 1) | ROM_LATENCY'(issue);
      infl_q   <= infl_q + CNT_W'(issue) - CNT_W'(capture);
      fifo_cnt_q <= fifo_cnt_q + CNT_W'(capture) - CNT_W'(pop);
      if (accept) begin
        addr_q  <= '0;
        pass_q  <= '0;
        npass_q <= num_passes;
      end else if (issue) begin
        if (addr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
          addr_q <= '0;
          pass_q <= pass_q + 1'b1;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end
      if (capture)
        wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: fifo_cnt_q gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (capture) mem_q[wr_ptr_q] <= rom_q;
  end

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Randomized bench for weight_stream_ctrl with a queue-based reference model
// and a behavioural two-cycle ROM.
module tb_weight_stream_ctrl;
  localparam int DW = 32;
  localparam int MD = 4;
  localparam int AW = $clog2(MD) + 1;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] num_passes = '0;
  logic          busy, done, rom_ce, data_out_valid;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q, data_out;
  logic          data_out_ready = 1'b0;

  weight_stream_ctrl #(.DATA_WIDTH(DW), .MEM_DEPTH(MD), .ADDR_WIDTH(AW),
                       .ROM_LATENCY(2), .PASS_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_passes(num_passes),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_ce(rom_ce),
    .rom_q(rom_q), .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready));

  always #5 clk = ~clk;

  logic [DW-1:0] rom [MD];
  logic [AW-1:0] rom_a1 = '0;
  always @(posedge clk) begin
    if (rom_ce) begin
      rom_a1 <= rom_addr;
      rom_q  <= rom[rom_a1[1:0]];
    end
  end

  int ready_mode = 0;  // 0 low, 1 high, 2 random
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       data_out_ready = 1'b0;
      1:       data_out_ready = 1'b1;
      default: data_out_ready = 1'($urandom % 2);
    endcase
  end

  int n_pass = 0, n_tot = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // reference model state
  logic [DW-1:0] exp_q [$];
  bit m_active = 0, m_fin = 0, m_zero = 0;
  bit stall_pend = 0, fv_seen = 0;
  logic [DW-1:0] stall_data;
  int beats = 0, done_cnt = 0, t_start = 0, t_fv = 0, t_done = 0;

  always @(negedge clk) begin
    bit nf, nz;
    if (!rst_n) begin
      chk("rst_valid", data_out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ce", rom_ce, 0);
      chk("rst_addr", rom_addr, 0);
      exp_q.delete();
      m_active = 0; m_fin = 0; m_zero = 0; stall_pend = 0;
    end else begin
      chk("done", done, m_fin | m_zero);
      chk("busy", busy, m_active | m_fin);
      chk("rom_ce", rom_ce, m_active);
      chk("fifo_bound", dut.fifo_cnt_q <= 4, 1);
      if (!m_active) chk("idle_valid", data_out_valid, 0);
      if (stall_pend) begin
        chk("stall_valid", data_out_valid, 1);
        chk("stall_data", data_out, stall_data);
      end
      if (data_out_valid) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else chk("beat_data", data_out, exp_q[0]);
        if (!fv_seen) begin t_fv = cyc; fv_seen = 1; end
      end
      nf = 0; nz = 0;
      stall_pend = data_out_valid && !data_out_ready;
      stall_data = data_out;
      if (done) begin done_cnt++; t_done = cyc; end
      if (data_out_valid && data_out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        beats++;
        if (exp_q.size() == 0 && m_active) begin nf = 1; m_active = 0; end
      end
      if (start && !(m_active || m_fin)) begin
        if (num_passes == 0) nz = 1;
        else begin
          for (int p = 0; p < int'(num_passes); p++)
            for (int a = 0; a < MD; a++) exp_q.push_back(rom[a]);
          m_active = 1; t_start = cyc + 1; fv_seen = 0;
        end
      end
      m_fin = nf; m_zero = nz;
    end
  end

  task automatic pulse_start(input int n, input int hold);
    @(posedge clk); #2;
    start = 1'b1; num_passes = PW'(n);
    repeat (hold) @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int base = done_cnt;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      if (done_cnt > base) break;
    end
    chk("done_seen", done_cnt > base, 1);
    repeat (2) @(posedge clk);
  endtask

  int b0, d0, n;
  initial begin
    for (int a = 0; a < MD; a++) rom[a] = $urandom;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // single pass, ready high: literal latency pins
    ready_mode = 1; b0 = beats; d0 = done_cnt;
    pulse_start(1, 1);
    wait_done(100);
    chk("t1_first_valid", t_fv - t_start, 3);
    chk("t1_done_lat", t_done - t_start, 7);
    chk("t1_beats", beats - b0, 4);
    chk("t1_dones", done_cnt - d0, 1);

    // three passes
    b0 = beats; d0 = done_cnt;
    pulse_start(3, 1);
    wait_done(200);
    chk("t2_done_lat", t_done - t_start, 15);
    chk("t2_beats", beats - b0, 12);
    chk("t2_dones", done_cnt - d0, 1);

    // random ready, two passes then a few random runs
    ready_mode = 2;
    for (int it = 0; it < 5; it++) begin
      n = (it == 0) ? 2 : int'($urandom_range(1, 3));
      b0 = beats;
      pulse_start(n, 1);
      wait_done(400);
      chk("rand_beats", beats - b0, 4 * n);
    end

    // consumer stalled 20 cycles
    ready_mode = 0; b0 = beats;
    pulse_start(1, 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("stall_addr_wrapped", rom_addr, 0);
    chk("stall_held_valid", data_out_valid, 1);
    chk("stall_beat0", data_out, rom[0]);
    ready_mode = 1;
    wait_done(100);
    chk("stall_beats", beats - b0, 4);

    // reset mid pass 2
    b0 = beats;
    pulse_start(3, 1);
    for (int i = 0; i < 100 && beats - b0 < 6; i++) @(posedge clk);
    chk("mid_reach", beats - b0 >= 6, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("async_valid", data_out_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_ce", rom_ce, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    b0 = beats; d0 = done_cnt;
    pulse_start(1, 1);
    wait_done(100);
    chk("post_rst_beats", beats - b0, 4);
    chk("post_rst_dones", done_cnt - d0, 1);

    // zero passes
    b0 = beats; d0 = done_cnt;
    pulse_start(0, 1);
    wait_done(10);
    chk("zero_beats", beats - b0, 0);
    chk("zero_dones", done_cnt - d0, 1);

    // start held high while busy
    b0 = beats; d0 = done_cnt;
    pulse_start(1, 6);
    wait_done(100);
    chk("hold_beats", beats - b0, 4);
    chk("hold_dones", done_cnt - d0, 1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
